// File: rtl/loader_pkg.sv
// Shared types and AXI encodings for the boot-image loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;

endpackage

// File: rtl/axi_ram_loader_if.sv
// Image beat stream plus AXI4 write channels between the image source, loader and axi_ram.
interface axi_ram_loader_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 5
);
  logic                      s_img_valid;
  logic                      s_img_ready;
  logic [DATA_WIDTH-1:0]     s_img_data;
  logic                      s_img_last;

  logic                      M_AXI_awvalid;
  logic                      M_AXI_awready;
  logic [ID_WIDTH-1:0]       M_AXI_awid;
  logic [ADDR_WIDTH-1:0]     M_AXI_awaddr;
  logic [7:0]                M_AXI_awlen;
  logic [2:0]                M_AXI_awsize;
  logic [1:0]                M_AXI_awburst;

  logic                      M_AXI_wvalid;
  logic                      M_AXI_wready;
  logic [DATA_WIDTH-1:0]     M_AXI_wdata;
  logic [DATA_WIDTH/8-1:0]   M_AXI_wstrb;
  logic                      M_AXI_wlast;

  logic                      M_AXI_bvalid;
  logic                      M_AXI_bready;
  logic [1:0]                M_AXI_bresp;

  // loader side
  modport master (
    input  s_img_valid, s_img_data, s_img_last,
    output s_img_ready,
    output M_AXI_awvalid, M_AXI_awid, M_AXI_awaddr, M_AXI_awlen, M_AXI_awsize, M_AXI_awburst,
    input  M_AXI_awready,
    output M_AXI_wvalid, M_AXI_wdata, M_AXI_wstrb, M_AXI_wlast,
    input  M_AXI_wready,
    input  M_AXI_bvalid, M_AXI_bresp,
    output M_AXI_bready
  );

  // image source + RAM side
  modport slave (
    output s_img_valid, s_img_data, s_img_last,
    input  s_img_ready,
    input  M_AXI_awvalid, M_AXI_awid, M_AXI_awaddr, M_AXI_awlen, M_AXI_awsize, M_AXI_awburst,
    output M_AXI_awready,
    input  M_AXI_wvalid, M_AXI_wdata, M_AXI_wstrb, M_AXI_wlast,
    output M_AXI_wready,
    output M_AXI_bvalid, M_AXI_bresp,
    input  M_AXI_bready
  );

endinterface

// File: rtl/loader_beat_buf.sv
// One-burst beat buffer: write pointer doubles as the beat count, read pointer walks the W phase.
module loader_beat_buf #(
  parameter  int BURST_LEN  = 16,
  parameter  int DATA_WIDTH = 64,
  localparam int IDX_W      = $clog2(BURST_LEN),
  localparam int CNT_W      = IDX_W + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_adv,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0]      count,
  output logic [CNT_W-1:0]      rd_ptr
);

  logic [DATA_WIDTH-1:0] mem [BURST_LEN];

  // storage needs no reset: nothing is read before it is written in the same burst
  always_ff @(posedge clock) begin
    if (wr_en) mem[count[IDX_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      count  <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)  count  <= count + CNT_W'(1);
      if (rd_adv) rd_ptr <= rd_ptr + CNT_W'(1);
    end
  end

  assign rd_data = mem[rd_ptr[IDX_W-1:0]];

endmodule

// File: rtl/axi_ram_loader.sv
// Packs the boot-image beat stream into AXI4 INCR bursts and holds the core in reset
// until every burst has been acknowledged OKAY.
//
// state    | meaning
// ST_FILL  | accepting image beats into the burst buffer
// ST_AW    | presenting the burst address
// ST_W     | streaming buffered beats
// ST_B     | waiting for the write response
// ST_DONE  | image loaded, core released (absorbing)
// ST_ERROR | non-OKAY response seen, core held (absorbing)
module axi_ram_loader
  import loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ID_WIDTH   = 5,
  parameter int                    BURST_LEN  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h8000_0000
) (
  input  logic            clock,
  input  logic            reset,
  axi_ram_loader_if.master bus,
  output logic            core_reset,
  output logic            load_done,
  output logic            load_error
);

  localparam int CNT_W      = $clog2(BURST_LEN) + 1;
  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  img_end;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  img_hs;
  logic                  w_hs;
  logic                  last_rd;
  logic                  burst_ok;

  assign img_hs   = bus.s_img_valid && bus.s_img_ready;
  assign w_hs     = bus.M_AXI_wvalid && bus.M_AXI_wready;
  assign last_rd  = (rd_ptr == count - CNT_W'(1));
  assign burst_ok = (state == ST_B) && bus.M_AXI_bvalid && (bus.M_AXI_bresp == AXI_RESP_OKAY);

  loader_beat_buf #(
    .BURST_LEN  (BURST_LEN),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_beat_buf (
    .clock   (clock),
    .reset   (reset),
    .clr     (burst_ok),
    .wr_en   (img_hs),
    .wr_data (bus.s_img_data),
    .rd_adv  (w_hs),
    .rd_data (rd_data),
    .count   (count),
    .rd_ptr  (rd_ptr)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_FILL;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr    <= BASE_ADDR;
      img_end <= 1'b0;
    end else begin
      if (img_hs && bus.s_img_last) img_end <= 1'b1;
      if (burst_ok) addr <= addr + (ADDR_WIDTH'(count) << BYTE_SHIFT);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL: if (img_hs && (bus.s_img_last || count == CNT_W'(BURST_LEN - 1))) state_nxt = ST_AW;
      ST_AW:   if (bus.M_AXI_awready) state_nxt = ST_W;
      ST_W:    if (w_hs && last_rd) state_nxt = ST_B;
      ST_B: begin
        if (bus.M_AXI_bvalid) begin
          if (bus.M_AXI_bresp != AXI_RESP_OKAY) state_nxt = ST_ERROR;
          else if (img_end)                    state_nxt = ST_DONE;
          else                                 state_nxt = ST_FILL;
        end
      end
      default: state_nxt = state;
    endcase
  end

  // ready is masked while reset is held so the source sees no acceptance during reset
  always_comb begin
    bus.s_img_ready   = 1'b0;
    bus.M_AXI_awvalid = 1'b0;
    bus.M_AXI_wvalid  = 1'b0;
    bus.M_AXI_bready  = 1'b0;
    core_reset        = 1'b1;
    load_done         = 1'b0;
    load_error        = 1'b0;
    case (state)
      ST_FILL:  bus.s_img_ready   = !reset;
      ST_AW:    bus.M_AXI_awvalid = 1'b1;
      ST_W:     bus.M_AXI_wvalid  = 1'b1;
      ST_B:     bus.M_AXI_bready  = 1'b1;
      ST_DONE: begin
        core_reset = 1'b0;
        load_done  = 1'b1;
      end
      ST_ERROR: load_error = 1'b1;
      default: ;
    endcase
  end

  assign bus.M_AXI_awid    = ID_WIDTH'(0);
  assign bus.M_AXI_awaddr  = addr;
  assign bus.M_AXI_awlen   = 8'(count - CNT_W'(1));
  assign bus.M_AXI_awsize  = AXI_SIZE_8B;
  assign bus.M_AXI_awburst = AXI_BURST_INCR;
  assign bus.M_AXI_wdata   = rd_data;
  assign bus.M_AXI_wstrb   = '1;
  assign bus.M_AXI_wlast   = last_rd;

endmodule

// File: tb/tb_axi_ram_loader.sv
// Scoreboard bench for axi_ram_loader: directed images, an AXI slave/RAM model and a monitor.
module tb_axi_ram_loader;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic core_reset, load_done, load_error;

  always #5 clock = ~clock;

  axi_ram_loader_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .ID_WIDTH(5)) bus ();

  axi_ram_loader #(
    .ADDR_WIDTH (64),
    .DATA_WIDTH (64),
    .ID_WIDTH   (5),
    .BURST_LEN  (16),
    .BASE_ADDR  (64'h8000_0000)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
  } aw_exp_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } w_exp_t;

  aw_exp_t     aw_q[$];
  w_exp_t      w_q[$];
  logic [63:0] ram [logic [63:0]];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        stall_en = 1'b0;
  int          err_burst = 0;
  int          b_pending = 0;
  int          b_count = 0;
  int          w_total = 0;
  logic [63:0] wr_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] img_word(input int tag, input int i);
    if (tag == 0) return 64'hDEAD;
    return {16'hB007, 16'(tag), 32'(i * 7 + 3)};
  endfunction

  function automatic logic [63:0] ram_rd(input logic [63:0] a);
    if (ram.exists(a)) return ram[a];
    return 64'hx;
  endfunction

  task automatic push_aw(input logic [63:0] a, input logic [7:0] l);
    aw_q.push_back('{a, l});
  endtask

  // beats 0..limit-1 of an n-beat image; wlast every 16th beat and on the image end
  task automatic push_w(input int n, input int tag, input int limit);
    for (int i = 0; i < limit; i++)
      w_q.push_back('{img_word(tag, i), (i % 16 == 15) || (i == n - 1)});
  endtask

  // AXI slave + RAM model + scoreboard monitor
  initial begin
    aw_exp_t     ea;
    w_exp_t      ew;
    logic        aw_stall_p, w_stall_p, w_last_p;
    logic [63:0] aw_addr_p, w_data_p;
    logic [7:0]  aw_len_p;
    aw_stall_p = 1'b0; w_stall_p = 1'b0; w_last_p = 1'b0;
    aw_addr_p = '0; w_data_p = '0; aw_len_p = '0;
    bus.M_AXI_awready = 1'b0;
    bus.M_AXI_wready  = 1'b0;
    bus.M_AXI_bvalid  = 1'b0;
    bus.M_AXI_bresp   = 2'b00;
    forever begin
      @(negedge clock);
      if (reset) begin
        aw_stall_p = 1'b0;
        w_stall_p  = 1'b0;
        b_pending  = 0;
        b_count    = 0;
      end else begin
        if (aw_stall_p) begin
          check("aw_hold_valid", bus.M_AXI_awvalid, 1);
          check("aw_hold_addr", bus.M_AXI_awaddr, aw_addr_p);
          check("aw_hold_len", bus.M_AXI_awlen, aw_len_p);
        end
        if (w_stall_p) begin
          check("w_hold_valid", bus.M_AXI_wvalid, 1);
          check("w_hold_data", bus.M_AXI_wdata, w_data_p);
          check("w_hold_last", bus.M_AXI_wlast, w_last_p);
        end
        if (bus.M_AXI_awvalid && bus.M_AXI_awready) begin
          if (aw_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_aw: got addr 0x%0h len %0d, expected no AW", bus.M_AXI_awaddr, bus.M_AXI_awlen);
          end else begin
            ea = aw_q.pop_front();
            check("awaddr", bus.M_AXI_awaddr, ea.addr);
            check("awlen", bus.M_AXI_awlen, ea.len);
            check("awsize", bus.M_AXI_awsize, 3);
            check("awburst", bus.M_AXI_awburst, 1);
            check("awid", bus.M_AXI_awid, 0);
          end
          check("aw_w_overlap", bus.M_AXI_wvalid, 0);
          wr_addr = bus.M_AXI_awaddr;
        end
        if (bus.M_AXI_wvalid && bus.M_AXI_wready) begin
          if (w_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_w: got data 0x%0h, expected no W beat", bus.M_AXI_wdata);
          end else begin
            ew = w_q.pop_front();
            check("wdata", bus.M_AXI_wdata, ew.data);
            check("wlast", bus.M_AXI_wlast, ew.last);
            check("wstrb", bus.M_AXI_wstrb, 64'hff);
          end
          ram[wr_addr] = bus.M_AXI_wdata;
          wr_addr = wr_addr + 64'd8;
          w_total++;
          if (bus.M_AXI_wlast) b_pending++;
        end
        if (bus.M_AXI_bvalid && bus.M_AXI_bready) begin
          b_pending--;
          b_count++;
        end
        aw_stall_p = bus.M_AXI_awvalid && !bus.M_AXI_awready;
        aw_addr_p  = bus.M_AXI_awaddr;
        aw_len_p   = bus.M_AXI_awlen;
        w_stall_p  = bus.M_AXI_wvalid && !bus.M_AXI_wready;
        w_data_p   = bus.M_AXI_wdata;
        w_last_p   = bus.M_AXI_wlast;
      end
      @(posedge clock);
      #1;
      if (reset) begin
        bus.M_AXI_awready = 1'b0;
        bus.M_AXI_wready  = 1'b0;
        bus.M_AXI_bvalid  = 1'b0;
      end else begin
        bus.M_AXI_awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.M_AXI_wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (b_pending <= 0) bus.M_AXI_bvalid = 1'b0;
        else if (!bus.M_AXI_bvalid) bus.M_AXI_bvalid = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.M_AXI_bresp = (b_count + 1 == err_burst) ? 2'b10 : 2'b00;
      end
    end
  end

  // image source; gives up quietly on reset, or on a stall when blocking is expected
  task automatic send_image(input int n, input int tag, input bit allow_block);
    bit abort;
    bit accepted;
    bit ready_seen;
    int budget;
    abort = 1'b0;
    for (int i = 0; i < n && !abort; i++) begin
      if (stall_en && $urandom_range(0, 3) == 0) begin
        bus.s_img_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1;
      end
      bus.s_img_valid = 1'b1;
      bus.s_img_data  = img_word(tag, i);
      bus.s_img_last  = (i == n - 1);
      accepted = 1'b0;
      budget   = 0;
      while (!accepted && !abort) begin
        @(negedge clock);
        ready_seen = bus.s_img_ready;
        if (reset) abort = 1'b1;
        else begin
          @(posedge clock);
          #1;
          if (ready_seen) accepted = 1'b1;
          else begin
            budget++;
            if (budget > 300) begin
              abort = 1'b1;
              if (!allow_block) begin
                n_checks++; n_fail++;
                $display("FAIL img_accept_timeout: beat %0d not accepted, expected acceptance", i);
              end
            end
          end
        end
      end
    end
    bus.s_img_valid = 1'b0;
    bus.s_img_last  = 1'b0;
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    while (!(load_done || load_error) && k < 3000) begin
      @(posedge clock);
      #1;
      k++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_img_ready"}, bus.s_img_ready, 0);
    check({tag, "_awvalid"}, bus.M_AXI_awvalid, 0);
    check({tag, "_wvalid"}, bus.M_AXI_wvalid, 0);
    check({tag, "_bready"}, bus.M_AXI_bready, 0);
    check({tag, "_core_reset"}, core_reset, 1);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_load_error"}, load_error, 0);
  endtask

  task automatic apply_reset();
    bus.s_img_valid = 1'b0;
    bus.s_img_last  = 1'b0;
    @(posedge clock);
    #3;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    aw_q.delete();
    w_q.delete();
    ram.delete();
    w_total = 0;
    reset = 1'b0;
  endtask

  task automatic check_ram(input string name, input int n, input int tag);
    for (int i = 0; i < n; i++)
      check(name, ram_rd(BASE + 64'(i * 8)), img_word(tag, i));
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_aw_left"}, 64'(aw_q.size()), 0);
    check({tag, "_w_left"}, 64'(w_q.size()), 0);
  endtask

  initial begin
    int k;
    bus.s_img_valid = 1'b0;
    bus.s_img_data  = '0;
    bus.s_img_last  = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_vals("rst");
    @(posedge clock);
    #1 reset = 1'b0;

    // single-beat image
    push_aw(BASE, 8'd0);
    w_q.push_back('{64'hDEAD, 1'b1});
    send_image(1, 0, 1'b0);
    wait_end();
    check("t1_core_reset", core_reset, 0);
    check("t1_load_done", load_done, 1);
    check("t1_load_error", load_error, 0);
    check("t1_img_ready", bus.s_img_ready, 0);
    check("t1_ram", ram_rd(BASE), 64'hDEAD);
    check_drained("t1");

    // 40 beats, three bursts, random stalls
    apply_reset();
    stall_en = 1'b1;
    push_aw(64'h8000_0000, 8'd15);
    push_aw(64'h8000_0080, 8'd15);
    push_aw(64'h8000_0100, 8'd7);
    push_w(40, 2, 40);
    send_image(40, 2, 1'b0);
    wait_end();
    check("t2_load_done", load_done, 1);
    check("t2_core_reset", core_reset, 0);
    check_ram("t2_ram", 40, 2);
    check_drained("t2");

    // exactly one full burst, no trailing AW
    apply_reset();
    stall_en = 1'b0;
    push_aw(64'h8000_0000, 8'd15);
    push_w(16, 3, 16);
    send_image(16, 3, 1'b0);
    wait_end();
    repeat (20) @(posedge clock);
    #1;
    check("t3_load_done", load_done, 1);
    check_ram("t3_ram", 16, 3);
    check_drained("t3");

    // SLVERR on the second burst
    apply_reset();
    err_burst = 2;
    push_aw(64'h8000_0000, 8'd15);
    push_aw(64'h8000_0080, 8'd15);
    push_w(40, 4, 32);
    send_image(40, 4, 1'b1);
    repeat (20) @(posedge clock);
    #1;
    check("t4_load_error", load_error, 1);
    check("t4_core_reset", core_reset, 1);
    check("t4_img_ready", bus.s_img_ready, 0);
    check("t4_load_done", load_done, 0);
    check_drained("t4");
    err_burst = 0;

    // reset in the middle of the second burst's W phase, then a clean reload
    apply_reset();
    stall_en = 1'b1;
    push_aw(64'h8000_0000, 8'd15);
    push_aw(64'h8000_0080, 8'd15);
    push_aw(64'h8000_0100, 8'd7);
    push_w(40, 5, 40);
    fork
      send_image(40, 5, 1'b1);
      begin
        k = 0;
        while (!(w_total >= 20 && bus.M_AXI_wvalid) && k < 3000) begin
          @(posedge clock);
          #1;
          k++;
        end
        check("t5_reached_w", 64'(w_total >= 20 && bus.M_AXI_wvalid), 1);
        #2 reset = 1'b1;
        #1 check_reset_vals("t5_rst");
        @(negedge clock);
        check_reset_vals("t5_rst_next");
      end
    join
    repeat (2) @(posedge clock);
    #1;
    aw_q.delete();
    w_q.delete();
    ram.delete();
    reset = 1'b0;
    push_aw(64'h8000_0000, 8'd15);
    push_aw(64'h8000_0080, 8'd3);
    push_w(20, 6, 20);
    send_image(20, 6, 1'b0);
    wait_end();
    check("t5_load_done", load_done, 1);
    check("t5_core_reset", core_reset, 0);
    check_ram("t5_ram", 20, 6);
    check_drained("t5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
